// File: rtl/vga_sync_monitor.sv
// VGA timing monitor: tracks hs/vs, reports active pixel position, probe capture, frame checksum and lock.
// Pixel outputs are registered one cycle behind the sampled inputs; lock reacts to errors the next cycle.
module vga_sync_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        de,
  output logic [11:0] rgb_q,
  output logic [11:0] probe_rgb,
  output logic        probe_valid,
  output logic [15:0] frame_sum,
  output logic        frame_pulse,
  output logic        err_h,
  output logic        err_v,
  output logic        locked
);

  typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_BEG  = 10'(H_START);
  localparam logic [9:0] H_END  = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_BEG  = 10'(V_START);
  localparam logic [9:0] V_END  = 10'(V_START + V_ACTIVE);

  logic        hs_q, vs_q;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        h_seen_q, v_seen_q;
  logic [15:0] acc_q, acc_d;
  logic        de_q;
  logic [9:0]  x_q, y_q;
  logic [11:0] pix_q, probe_rgb_q;
  logic        probe_valid_q;
  logic [15:0] frame_sum_q;
  logic        frame_pulse_q, err_h_q, err_v_q;

  state_t      state_q, state_d;
  logic [1:0]  good_q, good_d;
  logic        hbad_q, hbad_d;

  logic        hs_fall, vs_fall, act;
  logic        err_h_d, err_v_d, good_frame;
  logic [9:0]  x_c, y_c;
  logic [11:0] rgb;

  assign hs_fall = hs_q & ~hs;
  assign vs_fall = vs_q & ~vs;
  assign rgb     = {r, g, b};
  assign x_c     = h_cnt_q - H_BEG;
  assign y_c     = v_cnt_q - V_BEG;
  assign act     = (h_cnt_q >= H_BEG) && (h_cnt_q < H_END) &&
                   (v_cnt_q >= V_BEG) && (v_cnt_q < V_END);

  // Length checks stay quiet until one full line/frame has been bracketed since reset.
  assign err_h_d    = hs_fall & h_seen_q & (h_cnt_q != H_LAST);
  assign err_v_d    = vs_fall & v_seen_q & (v_cnt_q != V_LAST);
  assign good_frame = vs_fall & (v_cnt_q == V_LAST) & ~hbad_q & ~err_h_d;

  always_comb begin
    h_cnt_d = (h_cnt_q == 10'h3FF) ? h_cnt_q : h_cnt_q + 10'd1;
    if (hs_fall) begin
      h_cnt_d = '0;
    end
    v_cnt_d = v_cnt_q;
    if (vs_fall) begin
      v_cnt_d = '0;
    end else if (hs_fall && (v_cnt_q != 10'h3FF)) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end
    acc_d = acc_q + (act ? {4'd0, rgb} : 16'd0);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      acc_q         <= '0;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pix_q         <= '0;
      probe_rgb_q   <= '0;
      probe_valid_q <= 1'b0;
      frame_sum_q   <= '0;
      frame_pulse_q <= 1'b0;
      err_h_q       <= 1'b0;
      err_v_q       <= 1'b0;
    end else begin
      hs_q          <= hs;
      vs_q          <= vs;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_seen_q      <= h_seen_q | hs_fall;
      v_seen_q      <= v_seen_q | vs_fall;
      acc_q         <= vs_fall ? 16'd0 : acc_d;
      frame_pulse_q <= vs_fall;
      err_h_q       <= err_h_d;
      err_v_q       <= err_v_d;
      de_q          <= act;
      pix_q         <= rgb;
      if (vs_fall) begin
        frame_sum_q <= acc_d;
      end
      if (act) begin
        x_q <= x_c;
        y_q <= y_c;
      end
      if (act && (x_c == probe_x) && (y_c == probe_y)) begin
        probe_rgb_q   <= rgb;
        probe_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= SEARCH;
      good_q  <= '0;
      hbad_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      hbad_q  <= hbad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    // An err_h coinciding with vs_fall belongs to the frame that is ending.
    hbad_d  = vs_fall ? 1'b0 : (hbad_q | err_h_d);
    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (vs_fall) begin
          if (good_frame) begin
            good_d = good_q + 2'd1;
            if (good_d == 2'd2) begin
              state_d = LOCKED;
            end
          end else begin
            good_d = '0;
          end
        end
      end
      LOCKED: begin
        if (err_h_d || err_v_d) begin
          state_d = SEARCH;
          good_d  = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase
  end

  always_comb begin
    locked = 1'b0;
    if (state_q == LOCKED) begin
      locked = 1'b1;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign rgb_q       = pix_q;
  assign probe_rgb   = probe_rgb_q;
  assign probe_valid = probe_valid_q;
  assign frame_sum   = frame_sum_q;
  assign frame_pulse = frame_pulse_q;
  assign err_h       = err_h_q;
  assign err_v       = err_v_q;

endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 Parameters, each as name, default, meaning:
- H_TOTAL, 800, pixel clocks per line.
- H_START, 144, hs-fall-relative count of first active pixel (sync 96 + back porch 48).
- H_ACTIVE, 640, active pixels per line.
- V_TOTAL, 525, lines per frame.
- V_START, 35, vs-fall-relative line of first active line.
- V_ACTIVE, 480, active lines per frame.
REQ-002 Ports, each as name, direction, width, meaning:
- clk  in  1  pixel clock; the only clock.
- resetn  in  1  reset; synchronous and active-low.
- hs, vs  in  1 each  sync inputs, active-low.
- r, g, b  in  4 each  pixel colour.
- probe_x, probe_y  in  10 each  probe coordinate.
- x, y  out  10 each  position of the current active pixel.
- de  out  1  data enable; qualifies x, y and rgb_q.
- rgb_q  out  12  {r,g,b} aligned with de.
- probe_rgb  out  12  pixel captured at the probe coordinate.
- probe_valid  out  1  probe_rgb holds a capture.
- frame_sum  out  16  checksum of the last complete frame.
- frame_pulse  out  1  one-cycle pulse at each frame start.
- err_h, err_v  out  1 each  one-cycle pulses on bad line or frame length.
- locked  out  1  monitor is tracking a stable timing.

Function
REQ-003 Edge detect: hs_q and vs_q SHALL be registered copies of the inputs; hs_fall = hs_q & ~hs; vs_fall = vs_q & ~vs.
REQ-004 h_cnt (10 bit): SHALL load 0 on hs_fall; otherwise increment, saturating at 1023.
REQ-005 On hs_fall, if h_seen=1 and h_cnt != H_TOTAL-1, err_h SHALL pulse for one cycle. h_seen SHALL set on the first hs_fall.
REQ-006 v_cnt (10 bit): SHALL increment on hs_fall, saturating at 1023. On vs_fall it SHALL load 0; vs_fall has priority over a simultaneous hs_fall.
REQ-007 On vs_fall, if v_seen=1 and v_cnt != V_TOTAL-1, err_v SHALL pulse. v_seen SHALL set on the first vs_fall.
REQ-008 The active condition act SHALL be H_START <= h_cnt < H_START+H_ACTIVE and V_START <= v_cnt < V_START+V_ACTIVE. Both counters are evaluated with their values before the current cycle's update.
REQ-009 de, x = h_cnt-H_START, y = v_cnt-V_START and rgb_q SHALL be registered from act and {r,g,b}, giving 1-cycle latency. x and y SHALL hold their last value while de=0.
REQ-010 Probe: when act and the computed x==probe_x and y==probe_y, probe_rgb SHALL capture {r,g,b} and probe_valid SHALL set. A later matching pixel SHALL overwrite the capture; probe_valid SHALL never clear except at reset.
REQ-011 Checksum: an accumulator SHALL add the zero-extended {r,g,b} on every act cycle, wrapping mod 2^16.
REQ-012 On vs_fall, frame_sum SHALL load the accumulator value including any same-cycle addition; the accumulator SHALL clear; frame_pulse SHALL pulse. The first vs_fall after reset SHALL load frame_sum as well.
REQ-013 Lock FSM states: SEARCH, CHECK, LOCKED; locked=1 only in LOCKED.
- SEARCH -> CHECK on the first vs_fall.
- Good frame: a vs_fall with v_cnt==V_TOTAL-1 and no err_h since the previous vs_fall.
- CHECK: a 2-bit good-frame counter increments on each good frame and clears on a bad one. After the 2nd consecutive good frame -> LOCKED.
- LOCKED: any err_h or err_v -> SEARCH and locked SHALL drop the next cycle; the good-frame counter clears.
REQ-014 An err_h within a frame SHALL make that frame bad even if no further error occurs.
REQ-015 Simultaneous err_h and err_v SHALL both pulse; the FSM SHALL treat them as a single bad event.

Reset
REQ-016 While resetn=0 at a clk edge, all of the following SHALL clear:
- all outputs, including probe_rgb, probe_valid, frame_sum and locked;
- h_cnt, v_cnt, h_seen, v_seen and the accumulator;
- FSM state, set to SEARCH.
hs_q and vs_q SHALL load 1 so that no false edge is detected after reset.
REQ-017 Reset asserted mid-frame SHALL abandon the partial checksum. The monitor SHALL suppress err_h and err_v until after the first post-reset hs_fall and vs_fall, respectively.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Standard 640x480 timing with a constant colour 12'hF00 -> err_h and err_v never pulse; locked=1 after the 3rd vs_fall; each frame_sum = (307200*3840) mod 65536 = 16'h0000.
- Gradient input, rgb = x[3:0] replicated, with probe (0,0) and then (639,479) -> probe_rgb = 12'h000, then 12'hFFF; probe_valid=1.
- One line of 799 clocks while locked -> err_h pulses at the hs_fall ending that line; locked=0 the next cycle; relock after 2 further good frames.
- Frame of 524 lines -> err_v pulses at vs_fall; the FSM stays in CHECK or leaves LOCKED.
- vs and hs falling in the same cycle -> v_cnt=0, not 1; the first active line is still y=0 at line 35.
- resetn pulsed low mid-frame -> all outputs 0 the next cycle; no err pulses before the first post-reset edges.
